// File: rtl/sram_like_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mycpu_pkg
//  Description : Shared definitions for the sram-like responder: response
//                delay width, response-queue entry layout and the idle value
//                of the read-data bus.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

  localparam int SRAM_DELAY_W = 3;

  localparam logic [31:0] RDATA_RST_VAL = 32'h0000_0000;

  typedef struct packed {
    logic                    valid;
    logic                    is_wr;
    logic                    filled;
    logic [SRAM_DELAY_W-1:0] cnt;
    logic [31:0]             data;
  } q_entry_t;

endpackage : mycpu_pkg
`default_nettype wire

// File: rtl/sram_like_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_slave_if
//  Description : Sram-like request/response bus between a pipeline stage
//                (master) and the memory responder (slave).
//  Signals     : req, wen[3:0], addr[31:0], wdata[31:0], delay_cfg  (m -> s)
//                addr_ok, data_ok, rdata[31:0]                      (s -> m)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_like_slave_if;
  import mycpu_pkg::*;

  logic                    req;
  logic [3:0]              wen;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [SRAM_DELAY_W-1:0] delay_cfg;
  logic                    addr_ok;
  logic                    data_ok;
  logic [31:0]             rdata;

  modport master (
    output req, wen, addr, wdata, delay_cfg,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wen, addr, wdata, delay_cfg,
    output addr_ok, data_ok, rdata
  );

endinterface : sram_like_slave_if
`default_nettype wire

// File: rtl/sram_like_slave_resp_queue.sv
`default_nettype none
// ============================================================================
//  Module      : resp_queue
//  Description : DEPTH-entry circular buffer of outstanding responses. Each
//                entry counts down its extra delay and is filled with RAM read
//                data (or zero for writes) the cycle after it was pushed.
//  Ports       : clk, reset        - clock, async active-high reset
//                i_push/_is_wr/_cnt - allocate entry at tail
//                i_fill_data        - RAM read data for the pending fill
//                i_pop              - retire head entry
//                o_head             - current head entry
//                o_head_filling     - head is being filled this cycle
//                o_count            - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_queue
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_push_is_wr,
  input  logic [SRAM_DELAY_W-1:0] i_push_cnt,
  input  logic [31:0]             i_fill_data,
  input  logic                    i_pop,
  output q_entry_t                o_head,
  output logic                    o_head_filling,
  output logic [$clog2(DEPTH):0]  o_count
);

  // Index width kept at least 1 so DEPTH=1 still has a legal pointer.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  q_entry_t               r_q [DEPTH];
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [AW-1:0]          r_fill_idx;
  logic                   r_fill_pend;
  logic [$clog2(DEPTH):0] r_count;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_fill_idx  <= '0;
      r_fill_pend <= 1'b0;
      r_count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].valid && (r_q[i].cnt != '0)) begin
          r_q[i].cnt <= r_q[i].cnt - SRAM_DELAY_W'(1);
        end
      end

      // RAM data for the entry pushed last cycle lands now.
      if (r_fill_pend) begin
        r_q[r_fill_idx].filled <= 1'b1;
        r_q[r_fill_idx].data   <= r_q[r_fill_idx].is_wr ? 32'h0 : i_fill_data;
      end

      if (i_pop) begin
        r_q[r_head].valid <= 1'b0;
        r_head            <= f_next(r_head);
      end

      // A push never targets the head or the filling slot: acceptance is
      // blocked while full, so the tail slot is always free.
      if (i_push) begin
        r_q[r_tail] <= '{valid: 1'b1, is_wr: i_push_is_wr, filled: 1'b0,
                         cnt: i_push_cnt, data: 32'h0};
        r_tail      <= f_next(r_tail);
        r_fill_idx  <= r_tail;
      end
      r_fill_pend <= i_push;

      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head         = r_q[r_head];
  assign o_head_filling = r_fill_pend && (r_fill_idx == r_head);
  assign o_count        = r_count;

endmodule : resp_queue
`default_nettype wire

// File: rtl/sram_like_slave.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_slave
//  Description : Sram-like responder. Accepts up to DEPTH outstanding
//                requests, issues each on a synchronous single-port RAM in
//                acceptance order and returns in-order responses after a
//                per-request extra delay.
//  Ports       : clk, reset   - clock, async active-high reset
//                sbus         - sram-like bus (slave modport)
//                o_ram_en/_we/_addr/_wdata, i_ram_rdata - RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_like_slave
  import mycpu_pkg::*;
#(
  parameter int IDX_W = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  sram_like_slave_if.slave   sbus,
  output logic               o_ram_en,
  output logic [3:0]         o_ram_we,
  output logic [IDX_W-1:0]   o_ram_addr,
  output logic [31:0]        o_ram_wdata,
  input  logic [31:0]        i_ram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  q_entry_t        w_head;
  logic            w_head_filling;
  logic [CW-1:0]   w_count;
  logic            w_accept;
  logic            w_retire;
  logic [31:0]     w_resp_data;
  logic            w_addr_unused;

  // Occupancy before this cycle's retirement gates acceptance, so there is
  // no combinational path from data_ok back to addr_ok.
  assign w_accept = sbus.req && !reset && (w_count < CW'(DEPTH));

  assign w_retire = w_head.valid && (w_head.cnt == '0) &&
                    (w_head.filled || w_head_filling);

  // Bypass RAM output when the head is filled in the same cycle it retires.
  assign w_resp_data = w_head.filled ? w_head.data :
                       (w_head.is_wr ? 32'h0 : i_ram_rdata);

  assign sbus.addr_ok = w_accept;
  assign sbus.data_ok = w_retire;
  assign sbus.rdata   = w_retire ? w_resp_data : RDATA_RST_VAL;

  assign o_ram_en    = w_accept;
  assign o_ram_we    = w_accept ? sbus.wen : 4'h0;
  assign o_ram_addr  = w_accept ? sbus.addr[IDX_W+1:2] : '0;
  assign o_ram_wdata = w_accept ? sbus.wdata : 32'h0;

  assign w_addr_unused = ^{sbus.addr[31:IDX_W+2], sbus.addr[1:0]};

  resp_queue #(
    .DEPTH (DEPTH)
  ) u_resp_queue (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_accept),
    .i_push_is_wr   (|sbus.wen),
    .i_push_cnt     (sbus.delay_cfg),
    .i_fill_data    (i_ram_rdata),
    .i_pop          (w_retire),
    .o_head         (w_head),
    .o_head_filling (w_head_filling),
    .o_count        (w_count)
  );

endmodule : sram_like_slave
`default_nettype wire

// File: tb/tb_sram_like_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_like_slave
//  Description : Directed bench for sram_like_slave: a cycle-by-cycle vector
//                table plus hand-written wrap and async-reset sequences,
//                against a behavioural byte-writable synchronous RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_slave;
  import mycpu_pkg::*;

  localparam int IDX_W = 8;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_like_slave_if bus ();

  logic             ram_en;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  sram_like_slave #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sbus        (bus),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  // Behavioural RAM with a back-door preload port.
  logic [31:0]      mem [0:(1<<IDX_W)-1];
  logic             pl_en = 1'b0;
  logic [IDX_W-1:0] pl_addr;
  logic [31:0]      pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] d);
    bus.req       = req;
    bus.wen       = wen;
    bus.addr      = addr;
    bus.wdata     = wdata;
    bus.delay_cfg = d;
  endtask

  task automatic preload(input logic [IDX_W-1:0] a, input logic [31:0] v);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  d;
    logic        ok;
    logic        dok;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] d, input logic ok,
                              input logic dok, input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.wen = wen; v.addr = addr; v.wdata = wdata; v.d = d;
    v.ok = ok; v.dok = dok; v.rdata = rdata;
    return v;
  endfunction

  vec_t tv [15];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          issued;
    int          got;
    int          outst;
    logic [31:0] expq [$];

    //               req wen    addr        wdata         d  ok dok rdata
    tv[0]  = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);
    tv[1]  = mk(1'b1, 4'h0, 32'h40, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0);
    tv[2]  = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    tv[3]  = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);
    tv[4]  = mk(1'b1, 4'h0, 32'h00, 32'h0,        3'd3, 1'b1, 1'b0, 32'h0);
    tv[5]  = mk(1'b1, 4'h0, 32'h04, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0);
    tv[6]  = mk(1'b1, 4'h0, 32'h08, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);
    tv[7]  = mk(1'b1, 4'h0, 32'h08, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);
    tv[8]  = mk(1'b1, 4'h0, 32'h08, 32'h0,        3'd0, 1'b0, 1'b1, 32'h11111111);
    tv[9]  = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b1, 32'h22222222);
    tv[10] = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);
    tv[11] = mk(1'b1, 4'h3, 32'h08, 32'h12345678, 3'd0, 1'b1, 1'b0, 32'h0);
    tv[12] = mk(1'b1, 4'h0, 32'h08, 32'h0,        3'd0, 1'b1, 1'b1, 32'h0);
    tv[13] = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b1, 32'hAAAA5678);
    tv[14] = mk(1'b0, 4'h0, 32'h00, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0);

    // Reset values, with a write request presented during reset.
    drive(1'b1, 4'hF, 32'h44, 32'h55AA55AA, 3'd0);
    @(negedge clk);
    chk("rst_addr_ok",   bus.addr_ok, 1'b0);
    chk("rst_data_ok",   bus.data_ok, 1'b0);
    chk("rst_rdata",     bus.rdata,   32'h0);
    chk("rst_ram_en",    ram_en,      1'b0);
    chk("rst_ram_we",    ram_we,      4'h0);
    chk("rst_ram_addr",  ram_addr,    '0);
    chk("rst_ram_wdata", ram_wdata,   32'h0);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h00, 32'h11111111);
    preload(8'h01, 32'h22222222);
    preload(8'h02, 32'hAAAAAAAA);
    for (int i = 0; i < 10; i++) preload(8'(8'h40 + i), 32'hC0DE0000 | 32'(i));

    reset = 1'b0;

    // Table: single read, back-to-back with full stall, write then read.
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].req, tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_addr_ok", i), bus.addr_ok, tv[i].ok);
      chk($sformatf("v%0d_ram_en",  i), ram_en,      tv[i].ok);
      chk($sformatf("v%0d_data_ok", i), bus.data_ok, tv[i].dok);
      if (tv[i].dok) chk($sformatf("v%0d_rdata", i), bus.rdata, tv[i].rdata);
      @(posedge clk); #1;
    end

    // Ten reads at maximum rate with d=1, scoreboarded in order.
    issued = 0; got = 0; outst = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      if (issued < 10) drive(1'b1, 4'h0, 32'h100 + 32'(4*issued), 32'h0, 3'd1);
      else             drive(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
      @(negedge clk);
      chk("wrap_addr_ok", bus.addr_ok, (issued < 10) && (outst < DEPTH));
      if (bus.data_ok) begin
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL wrap_spurious_dok: got data_ok=1, expected 0");
        end else begin
          chk("wrap_rdata", bus.rdata, expq.pop_front());
        end
        got++;
        outst--;
      end
      if (bus.addr_ok) begin
        expq.push_back(32'hC0DE0000 | 32'(issued));
        issued++;
        outst++;
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
    chk("wrap_resp_count", 32'(got), 32'd10);

    // Async reset with two requests outstanding.
    drive(1'b1, 4'h0, 32'h0, 32'h0, 3'd1);
    @(posedge clk); #1;
    drive(1'b1, 4'h0, 32'h4, 32'h0, 3'd3);
    @(posedge clk); #1;
    drive(1'b1, 4'hF, 32'h3C, 32'hCAFEF00D, 3'd0);
    #1;
    chk("pre_rst_data_ok", bus.data_ok, 1'b1);
    chk("pre_rst_rdata",   bus.rdata,   32'h11111111);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr_ok",   bus.addr_ok, 1'b0);
    chk("mid_rst_data_ok",   bus.data_ok, 1'b0);
    chk("mid_rst_rdata",     bus.rdata,   32'h0);
    chk("mid_rst_ram_en",    ram_en,      1'b0);
    chk("mid_rst_ram_we",    ram_we,      4'h0);
    chk("mid_rst_ram_addr",  ram_addr,    '0);
    chk("mid_rst_ram_wdata", ram_wdata,   32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_dok", bus.data_ok, 1'b0);
    end
    @(posedge clk); #1;
    drive(1'b1, 4'h0, 32'h40, 32'h0, 3'd2);
    @(negedge clk);
    chk("post_rst_addr_ok", bus.addr_ok, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_dok_t%0d", k), bus.data_ok, (k == 3));
      if (k == 3) chk("post_rst_rdata", bus.rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_sram_like_slave
`default_nettype wire

// File: doc/sram_like_slave.md
# sram_like_slave

Responder end of the sram-like request/response protocol driven by the pipeline's fetch and memory stages (`req`/`addr_ok`/`data_ok`). It accepts up to `DEPTH` outstanding requests, performs each access on a synchronous single-port word RAM, and returns responses strictly in order after a runtime-programmable extra delay. It serves as the memory model behind the CPU and as the front of the future cache/AXI bridge.

## Interface
- `IDX_W`, 16: RAM word-index width; the RAM holds 2^IDX_W words.
- `DEPTH`, 2: maximum outstanding requests; must be a power of two, at least 1.
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `req` in 1: request valid.
- `wen` in 4: byte write strobes; 0 means a read.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `wdata` in 32: write data.
- `addr_ok` out 1: request accepted this cycle.
- `data_ok` out 1: one-cycle response pulse.
- `rdata` out 32: read data, valid when `data_ok`=1.
- `delay_cfg` in 3: extra response delay `d`, sampled at acceptance.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 4: RAM byte write enables.
- `ram_addr` out IDX_W: RAM word index, `addr[IDX_W+1:2]`.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_en`.

## Operation
- Handshake: `addr_ok = req && !reset && count < DEPTH`. `count` is the value before this cycle's retirement. No comb path from `data_ok` to `addr_ok`.
- On accept (cycle T):
  - RAM is driven the same cycle: `ram_en=1`, `ram_we=wen`, `ram_addr`, `ram_wdata=wdata`. `ram_en=0` otherwise.
  - A queue entry is allocated at the tail with `is_wr=|wen`, `filled=0`, `cnt=delay_cfg`.
- Cycle T+1: if `is_wr=0`, `ram_rdata` is written into the entry's data field and `filled` is set; a write entry is marked filled with data 0.
- Every cycle, each valid entry with `cnt!=0` decrements.
- Retire: the head entry retires when valid and `cnt==0`, and it is filled or being filled this cycle.
  - On retire: `data_ok=1`; `rdata` = stored data, or `ram_rdata` bypass when filled in the same cycle; writes return 32'h0.
  - Head pointer advances.
- At most one retirement per cycle. Non-head entries that reach `cnt==0` wait for the head.
- Writes always produce one `data_ok` acknowledge, ordered with reads.
- Read-after-write to the same word returns the new data, because RAM ops issue in acceptance order.

## Timing
- Response latency is `1+d` cycles after acceptance when the queue is empty ahead of the entry; otherwise the response comes no earlier than one cycle after the previous `data_ok`.
- Back-to-back accepts are allowed each cycle until `count==DEPTH`.
- Simultaneous accept and retire: count is unchanged, and the tail and head pointers both advance.
- Full: `addr_ok=0` even if the head retires that cycle; acceptance resumes the next cycle.
- Pointers wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits wide.
- Reset values: `addr_ok=0`, `data_ok=0`, `rdata=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`. The queue is empty and the pointers are 0.
- Reset mid-operation: all outstanding requests are dropped, and no `data_ok` is produced for them after reset deasserts. A RAM write already issued stays done.
- `req` deasserted without `addr_ok` is legal; there is no request-hold obligation.

## Structure
- Shared package `mycpu_pkg`: `SRAM_DELAY_W=3`, the queue-entry typedef {valid, is_wr, filled, cnt[2:0], data[31:0]}, and the reset-value constant for `rdata`.
- One sub-module, `resp_queue`, a DEPTH-entry circular buffer with push/pop/fill ports and count. The handshake, RAM drive, and retire logic stay in `sram_like_slave`.

## Test plan
- Single read, `d=0`:
  - Preload word 0x10 = 32'hDEADBEEF.
  - Drive req at addr 32'h40 in cycle 5.
  - Expect `addr_ok` in cycle 5, then `data_ok` with `rdata=DEADBEEF` in cycle 6.
- Back-to-back reads with varied delay:
  - Addr 0x0 with `d=3`, then addr 0x4 with `d=0` in the next cycle.
  - Responses arrive in order in cycles T+4 and T+5.
  - `addr_ok=0` in cycle T+2, because the queue is full.
- Write then read:
  - Write 32'h12345678 with `wen=4'b0011` to 0x8 (old word 32'hAAAAAAAA), then read 0x8.
  - Expect two `data_ok` pulses: the first with `rdata=0`, the second with `rdata=32'hAAAA5678`.
- Full wrap:
  - Run 10 consecutive reads with `d=1` at maximum rate.
  - Every request gets exactly one in-order response with correct data.
  - Pointers wrap cleanly, and `addr_ok` never asserts while `count==DEPTH`.
- Async reset mid-flight:
  - Assert `reset` between clock edges with 2 requests outstanding.
  - Outputs go to reset values immediately, and no `data_ok` occurs after release.
  - A new read issued afterwards completes with `1+d` latency.
